// File: rtl/if_fetch_stage.sv
// Instruction-fetch control: single-outstanding imem requests, IF/ID register, one-entry hold buffer.
// Optional IF_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o,
    output logic        pc_ce_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        id_stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_adel_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        kill_r, kill_s;
    logic [31:0] req_pc_r, req_pc_s;
    logic [31:0] hold_pc_r, hold_instr_r;
    logic        ifid_valid_r, ifid_adel_r;
    logic [31:0] ifid_pc_r, ifid_instr_r;

    logic        aligned_s, free_s, req_s, ce_s;
    logic        load_s, load_adel_s, park_s;
    logic [31:0] load_pc_s, load_instr_s;

    assign aligned_s    = (pc_i[1:0] == 2'b00);
    assign free_s       = !ifid_valid_r || !id_stall_i;
    assign npc_o        = flush_i ? redirect_pc_i : (pc_i + 32'd4);
    assign imem_addr_o  = pc_i;
    assign imem_req_o   = req_s;
    assign pc_ce_o      = ce_s;
    assign ifid_valid_o = ifid_valid_r;
    assign ifid_pc_o    = ifid_pc_r;
    assign ifid_instr_o = ifid_instr_r;
    assign ifid_adel_o  = ifid_adel_r;

    // Next-state, request/enable generation and IF/ID load selection.
    always_comb begin
        state_s      = state_r;
        kill_s       = kill_r;
        req_pc_s     = req_pc_r;
        req_s        = 1'b0;
        ce_s         = flush_i;
        load_s       = 1'b0;
        load_pc_s    = ifid_pc_r;
        load_instr_s = NOP_INSTR;
        load_adel_s  = 1'b0;
        park_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                req_s = aligned_s;
                if (aligned_s) begin
                    if (imem_gnt_i) begin
                        // A flush here leaves the old-PC request in flight; kill its response.
                        ce_s     = 1'b1;
                        req_pc_s = pc_i;
                        kill_s   = flush_i;
                        state_s  = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (!flush_i && free_s) begin
                    load_s      = 1'b1;
                    load_pc_s   = pc_i;
                    load_adel_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_r || flush_i) begin
                        kill_s  = 1'b0;
                        state_s = ST_REQ;
                    end else if (free_s) begin
                        load_s       = 1'b1;
                        load_pc_s    = req_pc_r;
                        load_instr_s = imem_rdata_i;
                        state_s      = ST_REQ;
                    end else begin
                        park_s  = 1'b1;
                        state_s = ST_HOLD;
                    end
                end else if (flush_i) begin
                    kill_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    state_s = ST_REQ;
                end else if (free_s) begin
                    load_s       = 1'b1;
                    load_pc_s    = hold_pc_r;
                    load_instr_s = hold_instr_r;
                    state_s      = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (!rst_n) begin
            req_s = 1'b0;
            ce_s  = 1'b0;
        end else begin
            req_s = req_s;
        end
    end

    // FSM state, kill flag and captured request PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            kill_r   <= 1'b0;
            req_pc_r <= RESET_VECTOR;
        end else begin
            state_r  <= state_s;
            kill_r   <= kill_s;
            req_pc_r <= req_pc_s;
        end
    end

    // Hold buffer: parks a response while ID is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_pc_r    <= RESET_VECTOR;
            hold_instr_r <= NOP_INSTR;
        end else if (flush_i) begin
            hold_pc_r    <= RESET_VECTOR;
            hold_instr_r <= NOP_INSTR;
        end else if (park_s) begin
            hold_pc_r    <= req_pc_r;
            hold_instr_r <= imem_rdata_i;
        end else begin
            hold_pc_r    <= hold_pc_r;
            hold_instr_r <= hold_instr_r;
        end
    end

    // IF/ID pipeline register; flush outranks any stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_valid_r <= 1'b0;
            ifid_pc_r    <= RESET_VECTOR;
            ifid_instr_r <= NOP_INSTR;
            ifid_adel_r  <= 1'b0;
        end else if (flush_i) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_adel_r  <= 1'b0;
        end else if (load_s) begin
            ifid_valid_r <= 1'b1;
            ifid_pc_r    <= load_pc_s;
            ifid_instr_r <= load_instr_s;
            ifid_adel_r  <= load_adel_s;
        end else if (free_s) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_adel_r  <= 1'b0;
        end else begin
            ifid_valid_r <= ifid_valid_r;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_r, perf_stall_r;

    assign perf_fetch_o = perf_fetch_r;
    assign perf_stall_o = perf_stall_r;

    // Wrapping counters of IF/ID loads and stalled-valid cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_r <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            perf_fetch_r <= (load_s && !flush_i) ? (perf_fetch_r + 32'd1) : perf_fetch_r;
            perf_stall_r <= (ifid_valid_r && id_stall_i) ? (perf_stall_r + 32'd1) : perf_stall_r;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage, plus a streaming fetch sequence.
module tb_if_fetch_stage;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] npc_o;
    logic        pc_ce_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_adel_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .npc_o         (npc_o),
        .pc_ce_o       (pc_ce_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_stall_i    (id_stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_adel_o   (ifid_adel_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        e_req;
        logic        e_ce;
        logic [31:0] e_npc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_adel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [31:0] pc, logic g, logic rv, logic [31:0] rd,
                                logic st, logic fl, logic [31:0] rdir, logic ereq, logic ece,
                                logic [31:0] enpc, logic ev, logic [31:0] epc, logic [31:0] ein,
                                logic ead);
        vec_t v;
        v.rst_n = r;   v.pc = pc;     v.gnt = g;      v.rv = rv;      v.rdata = rd;
        v.stall = st;  v.flush = fl;  v.redir = rdir; v.e_req = ereq; v.e_ce = ece;
        v.e_npc = enpc; v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_adel = ead;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic g, input logic rv,
                         input logic [31:0] rd, input logic st, input logic fl,
                         input logic [31:0] rdir);
        rst_n = r; pc_i = pc; imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
        id_stall_i = st; flush_i = fl; redirect_pc_i = rdir;
    endtask

    initial begin
        // rst pc gnt rv rdata stall flush redir | req ce npc | valid pc instr adel
        vecs.push_back(mk(0, RV, 0, 0, NOP, 0, 0, NOP, 0, 0, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(0, RV, 0, 0, NOP, 0, 0, NOP, 0, 0, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, RV, 1, 0, NOP, 0, 0, NOP, 0, 0, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, RV, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, 32'hBFC00004, 0, 1, 32'h3C080001, 0, 0, NOP, 0, 0, 32'hBFC00008, 1, RV, 32'h3C080001, 0));
        vecs.push_back(mk(1, 32'hBFC00004, 1, 0, NOP, 1, 0, NOP, 1, 1, 32'hBFC00008, 1, RV, 32'h3C080001, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 1, 32'h24090002, 1, 0, NOP, 0, 0, 32'hBFC0000C, 1, RV, 32'h3C080001, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 0, NOP, 1, 0, NOP, 0, 0, 32'hBFC0000C, 1, RV, 32'h3C080001, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 0, NOP, 0, 0, NOP, 0, 0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h24090002, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 0, NOP, 0, 0, NOP, 1, 0, 32'hBFC0000C, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'hBFC0000C, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'hBFC0000C, 0, 0, NOP, 0, 1, 32'h80000180, 0, 1, 32'h80000180, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'h80000180, 0, 0, NOP, 0, 0, NOP, 0, 0, 32'h80000184, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'h80000180, 0, 1, 32'hDEADBEEF, 0, 0, NOP, 0, 0, 32'h80000184, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'h80000180, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'h80000184, 0, 32'hBFC00004, NOP, 0));
        vecs.push_back(mk(1, 32'h80000184, 0, 1, 32'h11112222, 0, 0, NOP, 0, 0, 32'h80000188, 1, 32'h80000180, 32'h11112222, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFC, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'h00000000, 0, 32'h80000180, NOP, 0));
        vecs.push_back(mk(1, 32'h00000000, 0, 1, 32'hAAAA5555, 0, 0, NOP, 0, 0, 32'h00000004, 1, 32'hFFFFFFFC, 32'hAAAA5555, 0));
        vecs.push_back(mk(1, 32'hBFC00002, 1, 0, NOP, 0, 0, NOP, 0, 0, 32'hBFC00006, 1, 32'hBFC00002, NOP, 1));
        vecs.push_back(mk(1, 32'hBFC00002, 0, 0, NOP, 1, 0, NOP, 0, 0, 32'hBFC00006, 1, 32'hBFC00002, NOP, 1));
        vecs.push_back(mk(1, 32'hBFC00002, 0, 0, NOP, 1, 1, 32'h80000180, 0, 1, 32'h80000180, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(1, 32'h80000180, 1, 0, NOP, 0, 1, 32'h80000200, 1, 1, 32'h80000200, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(1, 32'h80000200, 0, 1, 32'hBADBAD00, 0, 0, NOP, 0, 0, 32'h80000204, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(1, 32'h80000200, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'h80000204, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(1, 32'h80000204, 0, 1, 32'hCAFE0001, 0, 1, 32'h80000300, 0, 1, 32'h80000300, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(1, 32'h80000300, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'h80000304, 0, 32'hBFC00002, NOP, 0));
        vecs.push_back(mk(0, 32'h80000304, 0, 0, NOP, 0, 0, NOP, 0, 0, 32'h80000308, 0, RV, NOP, 0));
        vecs.push_back(mk(1, RV, 0, 1, 32'hDEADDEAD, 0, 0, NOP, 0, 0, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, RV, 0, 0, NOP, 0, 0, NOP, 1, 0, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, RV, 1, 0, NOP, 0, 0, NOP, 1, 1, 32'hBFC00004, 0, RV, NOP, 0));
        vecs.push_back(mk(1, 32'hBFC00004, 0, 1, 32'h01010101, 0, 0, NOP, 0, 0, 32'hBFC00008, 1, RV, 32'h01010101, 0));
        vecs.push_back(mk(1, 32'hBFC00004, 1, 0, NOP, 1, 0, NOP, 1, 1, 32'hBFC00008, 1, RV, 32'h01010101, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 1, 32'h02020202, 1, 0, NOP, 0, 0, 32'hBFC0000C, 1, RV, 32'h01010101, 0));
        vecs.push_back(mk(1, 32'hBFC00008, 0, 0, NOP, 1, 1, 32'h80000180, 0, 1, 32'h80000180, 0, RV, NOP, 0));
        vecs.push_back(mk(1, 32'h80000180, 0, 0, NOP, 0, 0, NOP, 1, 0, 32'h80000184, 0, RV, NOP, 0));

        drive(1'b0, RV, 1'b0, 1'b0, NOP, 1'b0, 1'b0, NOP);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  vecs[i].stall, vecs[i].flush, vecs[i].redir);
            #2;
            chk($sformatf("v%0d imem_req", i), {31'd0, imem_req_o}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d pc_ce", i), {31'd0, pc_ce_o}, {31'd0, vecs[i].e_ce});
            chk($sformatf("v%0d npc", i), npc_o, vecs[i].e_npc);
            chk($sformatf("v%0d imem_addr", i), imem_addr_o, vecs[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ifid_valid", i), {31'd0, ifid_valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d ifid_pc", i), ifid_pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d ifid_instr", i), ifid_instr_o, vecs[i].e_instr);
            chk($sformatf("v%0d ifid_adel", i), {31'd0, ifid_adel_o}, {31'd0, vecs[i].e_adel});
        end

        // Streaming sequence: 1-cycle memory, ten back-to-back fetches.
        @(negedge clk);
        drive(1'b0, RV, 1'b0, 1'b0, NOP, 1'b0, 1'b0, NOP);
        @(negedge clk);
        drive(1'b1, RV, 1'b0, 1'b0, NOP, 1'b0, 1'b0, NOP);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, RV + 32'(4 * k), 1'b1, 1'b0, NOP, 1'b0, 1'b0, NOP);
            #2;
            chk($sformatf("s%0d req_ce", k), {30'd0, imem_req_o, pc_ce_o}, 32'd3);
            chk($sformatf("s%0d npc", k), npc_o, RV + 32'(4 * k + 4));
            @(negedge clk);
            drive(1'b1, RV + 32'(4 * k + 4), 1'b0, 1'b1, 32'h1000_0000 + 32'(k), 1'b0, 1'b0, NOP);
            @(posedge clk);
            #1;
            chk($sformatf("s%0d ifid_valid", k), {31'd0, ifid_valid_o}, 32'd1);
            chk($sformatf("s%0d ifid_pc", k), ifid_pc_o, RV + 32'(4 * k));
            chk($sformatf("s%0d ifid_instr", k), ifid_instr_o, 32'h1000_0000 + 32'(k));
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_o, 32'd10);
        chk("perf_stall0", perf_stall_o, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, RV + 32'd40, 1'b0, 1'b0, NOP, 1'b1, 1'b0, NOP);
        end
        @(posedge clk);
        #1;
        chk("perf_stall3", perf_stall_o, 32'd3);
`endif
        @(negedge clk);
        drive(1'b1, RV, 1'b0, 1'b0, NOP, 1'b0, 1'b0, NOP);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
